// File: rtl/cnnip_mem_resp.sv
// Byte-writable single-port buffer: controller has absolute priority, host uses spare cycles via req/gnt.
// Read latency 1, or 2 with CNNIP_MEM_OUT_REG_EN; out-of-range accesses read 0, drop writes, set sticky err_oor_o.
module cnnip_mem_resp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic                clk_a,
  input  logic                arstz_aq,
  input  logic                from_ctrlr_en_i,
  input  logic [DATA_W/8-1:0] from_ctrlr_we_i,
  input  logic [ADDR_W-1:0]   from_ctrlr_addr_i,
  input  logic [DATA_W-1:0]   from_ctrlr_din_i,
  output logic [DATA_W-1:0]   from_ctrlr_dout_o,
  input  logic                host_req_i,
  input  logic [DATA_W/8-1:0] host_be_i,
  input  logic [ADDR_W-1:0]   host_addr_i,
  input  logic [DATA_W-1:0]   host_wdata_i,
  output logic                host_gnt_o,
  output logic                host_rvalid_o,
  output logic [DATA_W-1:0]   host_rdata_o,
  input  logic                err_clr_i,
  output logic                err_oor_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              sel_host;
  logic              acc_vld;
  logic              acc_wr;
  logic              acc_oor;
  logic              rd_fire;
  logic [BE_W-1:0]   acc_be;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] rd_word;

  logic              err_oor_q, err_oor_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    sel_host  = host_req_i & ~from_ctrlr_en_i;
    acc_vld   = from_ctrlr_en_i | host_req_i;
    acc_be    = from_ctrlr_en_i ? from_ctrlr_we_i   : host_be_i;
    acc_addr  = from_ctrlr_en_i ? from_ctrlr_addr_i : host_addr_i;
    acc_wdata = from_ctrlr_en_i ? from_ctrlr_din_i  : host_wdata_i;
    acc_oor   = {1'b0, acc_addr} >= DEPTH_C;
    acc_idx   = acc_addr[IDX_W-1:0];
    acc_wr    = |acc_be;
    rd_fire   = acc_vld & ~acc_wr;
    // Index may alias a legal word when out of range, so the data is masked.
    rd_word   = acc_oor ? '0 : mem_q[acc_idx];
  end

  assign host_gnt_o = sel_host;

  // Array has no reset: contents survive arstz_aq.
  always_ff @(posedge clk_a) begin
    if (acc_vld && acc_wr && !acc_oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem_q[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    err_oor_d = err_oor_q;
    if (err_clr_i) err_oor_d = 1'b0;
    if (acc_vld && acc_oor) err_oor_d = 1'b1;
    rd_vld_d = rd_fire;
    rd_tag_d = sel_host;
  end

`ifdef CNNIP_MEM_OUT_REG_EN
  logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
  logic              host_rvalid_q, host_rvalid_d;

  always_comb begin
    rd_dat_d      = rd_fire ? rd_word : rd_dat_q;
    dout_d        = (rd_vld_q && !rd_tag_q) ? rd_dat_q : dout_q;
    host_rdata_d  = (rd_vld_q &&  rd_tag_q) ? rd_dat_q : host_rdata_q;
    host_rvalid_d = rd_vld_q & rd_tag_q;
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      rd_dat_q      <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      rd_dat_q      <= rd_dat_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign host_rvalid_o = host_rvalid_q;
`else
  always_comb begin
    dout_d       = (rd_fire && !sel_host) ? rd_word : dout_q;
    host_rdata_d = (rd_fire &&  sel_host) ? rd_word : host_rdata_q;
  end

  assign host_rvalid_o = rd_vld_q & rd_tag_q;
`endif

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      err_oor_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_tag_q     <= 1'b0;
      dout_q       <= '0;
      host_rdata_q <= '0;
    end else begin
      err_oor_q    <= err_oor_d;
      rd_vld_q     <= rd_vld_d;
      rd_tag_q     <= rd_tag_d;
      dout_q       <= dout_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign from_ctrlr_dout_o = dout_q;
  assign host_rdata_o      = host_rdata_q;
  assign err_oor_o         = err_oor_q;

endmodule

// File: tb/tb_cnnip_mem_resp.sv
// Directed bench for cnnip_mem_resp; expected read latency follows CNNIP_MEM_OUT_REG_EN.
module tb_cnnip_mem_resp;

`ifdef CNNIP_MEM_OUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk_a = 1'b0;
  logic        arstz_aq;
  logic        en;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        host_req;
  logic [3:0]  host_be;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        err_clr;
  logic        err_oor;

  int errors = 0;
  int checks = 0;

  cnnip_mem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(4096)) dut (
    .clk_a             (clk_a),
    .arstz_aq          (arstz_aq),
    .from_ctrlr_en_i   (en),
    .from_ctrlr_we_i   (we),
    .from_ctrlr_addr_i (addr),
    .from_ctrlr_din_i  (din),
    .from_ctrlr_dout_o (dout),
    .host_req_i        (host_req),
    .host_be_i         (host_be),
    .host_addr_i       (host_addr),
    .host_wdata_i      (host_wdata),
    .host_gnt_o        (host_gnt),
    .host_rvalid_o     (host_rvalid),
    .host_rdata_o      (host_rdata),
    .err_clr_i         (err_clr),
    .err_oor_o         (err_oor)
  );

  always #5 clk_a = ~clk_a;

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; we = '0; addr = '0; din = '0;
    host_req = 1'b0; host_be = '0; host_addr = '0; host_wdata = '0;
    err_clr = 1'b0;
  endtask

  task automatic ctrl_drive(input logic [3:0] w, input logic [15:0] a, input logic [31:0] d);
    en = 1'b1; we = w; addr = a; din = d;
  endtask

  task automatic host_drive(input logic [3:0] be, input logic [15:0] a, input logic [31:0] d);
    host_req = 1'b1; host_be = be; host_addr = a; host_wdata = d;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 00000000", dout); end
    checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL reset_host_rdata: got %h want 00000000", host_rdata); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", host_rvalid); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_oor); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", host_gnt); end
  endtask

  task automatic test_ctrl_rw();
    ctrl_drive(4'hF, 16'd5, 32'hDEADBEEF); tick(); idle();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL write_no_dout_change: got %h want 00000000", dout); end
    ctrl_drive(4'h0, 16'd5, 32'h0); tick(); idle();
    for (int k = 1; k < L; k++) begin
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rd_full_early: got %h want 00000000", dout); end
      tick();
    end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_full: got %h want DEADBEEF", dout); end
    // Partial write immediately followed by a read of the same word.
    ctrl_drive(4'b0010, 16'd5, 32'h00005500); tick();
    ctrl_drive(4'h0, 16'd5, 32'h0); tick(); idle();
    for (int k = 1; k < L; k++) begin
      checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_byte_early: got %h want DEADBEEF", dout); end
      tick();
    end
    checks++; if (dout !== 32'hDEAD55EF) begin errors++; $display("FAIL rd_byte: got %h want DEAD55EF", dout); end
  endtask

  task automatic test_arbitration();
    host_drive(4'h0, 16'd5, 32'h0);
    ctrl_drive(4'hF, 16'd6, 32'h00001234); #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL gnt_blocked_0: got %b want 0", host_gnt); end
    tick();
    ctrl_drive(4'h0, 16'd6, 32'h0); #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL gnt_blocked_1: got %b want 0", host_gnt); end
    tick(); #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL gnt_blocked_2: got %b want 0", host_gnt); end
    tick();
    en = 1'b0; #1;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL gnt_free: got %b want 1", host_gnt); end
    tick(); idle();
    for (int k = 1; k < L; k++) begin
      checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rvalid_early: got %b want 0", host_rvalid); end
      tick();
    end
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL host_rvalid: got %b want 1", host_rvalid); end
    checks++; if (host_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL host_rdata: got %h want DEAD55EF", host_rdata); end
    checks++; if (dout !== 32'h00001234) begin errors++; $display("FAIL host_rd_dout_kept: got %h want 00001234", dout); end
    tick();
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rvalid_pulse: got %b want 0", host_rvalid); end
    tick();
  endtask

  task automatic test_interleave();
    int pulses = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc == L - 1) begin
        checks++; if (dout !== 32'h00001234) begin errors++; $display("FAIL il_dout_before: got %h want 00001234", dout); end
      end
      if (cyc == L) begin
        checks++; if (dout !== 32'hDEAD55EF) begin errors++; $display("FAIL il_dout_first: got %h want DEAD55EF", dout); end
        checks++; if (host_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL il_hrdata_before: got %h want DEAD55EF", host_rdata); end
      end
      if (cyc == L + 1) begin
        checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL il_rvalid: got %b want 1", host_rvalid); end
        checks++; if (host_rdata !== 32'h00001234) begin errors++; $display("FAIL il_hrdata: got %h want 00001234", host_rdata); end
        checks++; if (dout !== 32'hDEAD55EF) begin errors++; $display("FAIL il_dout_kept: got %h want DEAD55EF", dout); end
      end
      if (host_rvalid === 1'b1) pulses++;
      idle();
      case (cyc)
        0: ctrl_drive(4'h0, 16'd5, 32'h0);
        1: host_drive(4'h0, 16'd6, 32'h0);
        2: ctrl_drive(4'h0, 16'd5, 32'h0);
        default: ;
      endcase
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL il_pulse_count: got %0d want 1", pulses); end
  endtask

  task automatic test_oor();
    ctrl_drive(4'hF, 16'd0, 32'hA5A5A5A5); tick(); idle();
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_idle: got %b want 0", err_oor); end
    ctrl_drive(4'hF, 16'd4096, 32'hFFFFFFFF); tick(); idle();
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", err_oor); end
    err_clr = 1'b1; tick(); idle();
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_clr1: got %b want 0", err_oor); end
    ctrl_drive(4'h0, 16'd0, 32'h0); tick(); idle();
    for (int k = 1; k < L; k++) tick();
    checks++; if (dout !== 32'hA5A5A5A5) begin errors++; $display("FAIL oor_wr_dropped: got %h want A5A5A5A5", dout); end
    ctrl_drive(4'h0, 16'd4096, 32'h0); tick(); idle();
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", err_oor); end
    for (int k = 1; k < L; k++) tick();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL oor_rd_dout: got %h want 00000000", dout); end
    host_drive(4'h0, 16'd4096, 32'h0); err_clr = 1'b1; #1;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL oor_host_gnt: got %b want 1", host_gnt); end
    tick(); idle();
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_set_wins: got %b want 1", err_oor); end
    for (int k = 1; k < L; k++) tick();
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL oor_host_rvalid: got %b want 1", host_rvalid); end
    checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL oor_host_rdata: got %h want 00000000", host_rdata); end
    err_clr = 1'b1; tick(); idle();
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_clr2: got %b want 0", err_oor); end
  endtask

  task automatic test_reset_mid_read();
    ctrl_drive(4'hF, 16'd4096, 32'h0); tick();
    ctrl_drive(4'h0, 16'd5, 32'h0); tick(); idle();
    for (int k = 0; k < L; k++) tick();
    checks++; if (dout !== 32'hDEAD55EF) begin errors++; $display("FAIL pre_rst_dout: got %h want DEAD55EF", dout); end
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL pre_rst_err: got %b want 1", err_oor); end
    host_drive(4'h0, 16'd6, 32'h0);
    for (int k = 1; k < L; k++) begin tick(); idle(); end
    #3 arstz_aq = 1'b0;
    #1;
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h want 00000000", dout); end
    checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h want 00000000", host_rdata); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_oor); end
    idle();
    tick(); tick();
    arstz_aq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_no_rvalid: got %b want 0", host_rvalid); end
      tick();
    end
    host_drive(4'h0, 16'd5, 32'h0); tick(); idle();
    for (int k = 1; k < L; k++) begin
      checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_rvalid_early: got %b want 0", host_rvalid); end
      tick();
    end
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL post_rst_rvalid: got %b want 1", host_rvalid); end
    checks++; if (host_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL post_rst_rdata: got %h want DEAD55EF", host_rdata); end
  endtask

  initial begin
    idle();
    arstz_aq = 1'b0;
    tick(); tick();
    test_reset();
    arstz_aq = 1'b1;
    tick();
    test_ctrl_rw();
    test_arbitration();
    test_interleave();
    test_oor();
    test_reset_mid_read();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnnip_mem_resp.md
# cnnip_mem_resp

Memory responder at the slave end of `cnnip_mem_if`: one single-port, byte-writable on-chip buffer instance. It serves CNN-controller accesses (input, weight or feature memory) at fixed latency with absolute priority. Spare cycles go to a host load/unload port with a request/grant handshake. It also flags out-of-range accesses.

## Interface
Parameters:
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `ADDR_W`, default 16: address width.
- `DEPTH`, default 4096: number of words, ≤ 2^ADDR_W.

Ports:
- `clk_a`  in  1  clock.
- `arstz_aq`  in  1  reset: asynchronous, active-low; clock `clk_a`.
- `from_ctrlr`  `cnnip_mem_if.slave`  —  controller port:
  - `en` 1
  - `we` DATA_W/8 (byte enables; any bit set = write)
  - `addr` ADDR_W
  - `din` DATA_W
  - `dout` DATA_W (driven by this block)
- `host_req`  in  1  host access request.
- `host_be`  in  DATA_W/8  host byte enables; all zero = read.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_gnt`  out  1  request accepted this cycle.
- `host_rvalid`  out  1  one-cycle pulse; `host_rdata` is valid.
- `host_rdata`  out  DATA_W  host read data.
- `err_clr`  in  1  clears `err_oor`.
- `err_oor`  out  1  sticky out-of-range flag.

## Operation
- Arbitration is combinational: `host_gnt = host_req & ~from_ctrlr.en`. The controller is never stalled and has no ready signal.
- Selected access per cycle: the controller if `en`, else the host if `host_req`, else none.
- Writes update only the bytes whose enable bit is set. A write never changes `dout` or `host_rdata` (no-change mode).
- Reads:
  - Read data goes into an internal read register.
  - A 1-bit source tag (ctrl/host) travels with it.
  - Controller reads update only `from_ctrlr.dout`. Host reads update only `host_rdata`.
  - Each output holds its last value until the next read from its own port.
- Out-of-range (`addr >= DEPTH`), on either port:
  - The write is dropped.
  - The read returns 0 and still completes normally: `dout` updates, or `host_rvalid` pulses.
  - `err_oor` is set.
- `err_oor` sticks until `err_clr`. If a set and `err_clr` occur in the same cycle, the set wins.
- A waiting host keeps `host_req` and all host fields stable until `host_gnt`. The block does not enforce this.

## Timing
- Reset values: `dout` = 0, `host_rdata` = 0, `host_rvalid` = 0, `err_oor` = 0, read-pipeline valid/tag = 0.
- Memory array contents are not reset. They are retained across `arstz_aq` but must be treated as undefined by users.
- Read latency L = 1 (base). A read issued in cycle N has data on its port output from cycle N+L. `host_rvalid` is high only in cycle N+L.
- Back-to-back reads sustain one per cycle on either port. Interleaved ctrl/host reads keep their own order and latency.
- Write in cycle N: the new data is visible to a read issued in cycle N+1.
- `host_gnt` is in the same cycle as the access. A grant occurs only in cycles where `en` = 0.
- `err_oor` rises in cycle N+1 after an out-of-range access in cycle N.
- Reset mid-operation:
  - All in-flight reads are discarded; no `host_rvalid` follows reset release.
  - Outputs go to their reset values immediately (asynchronously).

## Configuration
- Macro: `CNNIP_MEM_OUT_REG_EN`.
- Defined: an extra output register stage is added after the read register. L = 2 for both ports, and `host_rvalid` plus the source tag are delayed to match. Out-of-range reads still return 0, at N+2.
- Undefined: L = 1 as above.
- Write visibility, arbitration and `err_oor` timing are identical in both builds.

## Test plan
- Ctrl write/readback, DEPTH = 4096:
  - Write `addr` 5, `din` 0xDEADBEEF, `we` 4'hF; then read `addr` 5 → `dout` = 0xDEADBEEF at N+L.
  - Write `we` 4'b0010 with `din` 0x00005500 → next read = 0xDEAD55EF.
- Arbitration:
  - `host_req` held high for 3 cycles with ctrl `en` = 1 → `host_gnt` = 0 for 3 cycles.
  - Drop `en` → `host_gnt` = 1 in that cycle; the host read of 5 gives `host_rvalid` at +L with `host_rdata` = 0xDEAD55EF, and `dout` is unchanged.
- Interleave: ctrl read 5, host read 6 (holds 0x1234), ctrl read 5 on consecutive cycles → each port's data and latency are correct; exactly one `host_rvalid` pulse.
- Out-of-range: ctrl write `addr` 4096 with 0xFFFFFFFF, then read 4096 → `dout` = 0 and `err_oor` = 1.
  - `err_clr` asserted together with another out-of-range host read → `err_oor` stays 1.
  - `err_clr` alone → `err_oor` = 0.
- Reset mid-read: assert `arstz_aq` low in cycle N+L-1 of a host read → no `host_rvalid`; all outputs are 0; a post-reset read of `addr` 5 still completes with normal latency.
- Run all of the above with and without `CNNIP_MEM_OUT_REG_EN`, checking L = 1 and L = 2 respectively.
